// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-to-parallel receiver for the USB bit path.
//
// Shifts serial_in into a WIDTH-bit shift register on each shift_enable strobe, in LSB-first
// or MSB-first order. Each completed word moves into a holding register (data_out) and is
// offered to the consumer through a data_valid/data_ready handshake. If a word completes while
// the previous one is still unconsumed, the new word is dropped and the sticky overrun flag
// is set.
//
// Ports
//   clk           system clock, all logic on posedge
//   nRST          asynchronous active-low reset
//   clear         synchronous flush (SYNC/EOP boundary); overrides shift and handshake
//   shift_enable  sample serial_in this cycle
//   serial_in     received bit
//   data_ready    consumer accepts data_out this cycle
//   data_out      completed word (holding register)
//   data_valid    data_out holds an unconsumed word
//   overrun       sticky: a completed word was dropped
//   bit_count     bits accumulated in the current partial word
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             clear,
  input  logic             shift_enable,
  input  logic             serial_in,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);

  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] sr_shifted;
  logic             complete;

  // LSB-first: first bit travels down to bit 0 after WIDTH shifts.
  assign sr_shifted = LSB_FIRST ? {serial_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], serial_in};
  assign complete   = shift_enable && (cnt_q == LastCnt);

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (clear) begin
      sr_d      = '0;
      cnt_d     = '0;
      data_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (shift_enable) begin
        sr_d  = sr_shifted;
        cnt_d = complete ? '0 : cnt_q + CW'(1);
      end

      if (complete) begin
        // The holding register is free if empty or being consumed in this same cycle.
        if (!valid_q || data_ready) begin
          data_d  = sr_shifted;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (valid_q && data_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign bit_count  = cnt_q;

endmodule
